// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory controller: FSM states,
// the latched request record and the error/timeout defaults.
package dmem_pkg;

  localparam int          DMEM_ADDR_W  = 15;
  localparam int          TIMEOUT_DEF  = 64;
  localparam logic [15:0] ERR_DATA_DEF = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] addr;
    logic                   we;
    logic [15:0]            wdata;
  } req_t;

endpackage

// File: rtl/dmem_if.sv
// Data-bus port bundle between the controller (master) and the memory (slave).
interface dmem_if #(
  parameter int ADDR_W = 15
) ();

  // bus_req is held high with bus_we/bus_addr/bus_wdata stable until the slave
  // returns a one-cycle bus_ack; bus_rdata is valid only in the ack cycle.
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [15:0]       bus_wdata;
  logic              bus_ack;
  logic [15:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/dmem_wbuf.sv
// One-entry posted-write buffer; present only when DMEM_WBUF_EN is defined.
`ifdef DMEM_WBUF_EN
module dmem_wbuf
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  req_t i_entry,
  input  logic i_clear,
  output logic o_valid,
  output req_t o_entry
);

  logic r_valid;
  req_t r_entry;

  // Push only happens while empty and clear only while draining, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule
`endif

// File: rtl/dmem_ctrl.sv
// Bridges the single-cycle core's memr/memw to a req/ack data bus and stalls
// the core while the access is outstanding. DMEM_WBUF_EN enables posted stores.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          ADDR_W   = DMEM_ADDR_W,
  parameter int          TIMEOUT  = TIMEOUT_DEF,
  parameter logic [15:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memr,
  input  logic        memw,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_write_data,
  output logic [15:0] memr_data,
  output logic        stall,
  output logic        mem_err,
  dmem_if.master      bus,
  output state_t      o_dbg_state
);

  state_t      r_state, w_state_nxt;
  req_t        r_req, w_req_nxt;
  logic [15:0] r_rdata, w_rdata_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_is_load, w_is_load_nxt;
  logic        r_both, w_both_nxt;
  logic        r_drain, w_drain_nxt;
  logic        r_mem_err, w_err_set;
  logic        w_stall;

  logic        w_any, w_misalign, w_timeout, w_post_ok;
  req_t        w_in_req;
  logic        w_buf_valid, w_buf_push, w_buf_clear;
  req_t        w_buf_entry;

  assign w_any      = memr | memw;
  assign w_misalign = mem_address[0];
  assign w_timeout  = (r_cnt >= 8'(TIMEOUT - 1));

  always_comb begin
    w_in_req       = '0;
    w_in_req.addr  = mem_address[15 -: ADDR_W];
    w_in_req.we    = memw;
    w_in_req.wdata = mem_write_data;
  end

`ifdef DMEM_WBUF_EN
  assign w_post_ok = memw & ~memr;

  dmem_wbuf u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_buf_push),
    .i_entry (w_in_req),
    .i_clear (w_buf_clear),
    .o_valid (w_buf_valid),
    .o_entry (w_buf_entry)
  );
`else
  logic w_unused_wbuf;

  assign w_post_ok     = 1'b0;
  assign w_buf_valid   = 1'b0;
  assign w_buf_entry   = '0;
  assign w_unused_wbuf = w_buf_push ^ w_buf_clear;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_rdata_nxt   = r_rdata;
    w_cnt_nxt     = r_cnt;
    w_is_load_nxt = r_is_load;
    w_both_nxt    = r_both;
    w_drain_nxt   = r_drain;
    w_err_set     = 1'b0;
    w_stall       = 1'b0;
    w_buf_push    = 1'b0;
    w_buf_clear   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_buf_valid) begin
          // A pending posted store always drains first; the core waits behind it.
          w_stall     = w_any;
          w_req_nxt   = w_buf_entry;
          w_drain_nxt = 1'b1;
          w_both_nxt  = 1'b0;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = REQ;
        end else if (w_any) begin
          if (w_misalign) begin
            w_stall       = 1'b1;
            w_err_set     = 1'b1;
            w_rdata_nxt   = ERR_DATA;
            w_is_load_nxt = memr & ~memw;
            w_state_nxt   = DONE;
          end else if (w_post_ok) begin
            w_buf_push = 1'b1;
          end else begin
            w_stall       = 1'b1;
            w_req_nxt     = w_in_req;
            w_is_load_nxt = ~memw;
            w_both_nxt    = memr & memw;
            w_drain_nxt   = 1'b0;
            w_cnt_nxt     = 8'd0;
            w_state_nxt   = REQ;
          end
        end
      end

      REQ: begin
        w_stall = r_drain ? w_any : 1'b1;
        if (bus.bus_ack) begin
          if (r_drain) begin
            w_buf_clear = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_rdata_nxt = bus.bus_rdata;
            w_err_set   = r_both;
            w_state_nxt = DONE;
          end
        end else if (w_timeout) begin
          w_err_set = 1'b1;
          if (r_drain) begin
            w_buf_clear = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_rdata_nxt = ERR_DATA;
            w_state_nxt = DONE;
          end
        end else begin
          w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_rdata   <= '0;
      r_cnt     <= '0;
      r_is_load <= 1'b0;
      r_both    <= 1'b0;
      r_drain   <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_rdata   <= w_rdata_nxt;
      r_cnt     <= w_cnt_nxt;
      r_is_load <= w_is_load_nxt;
      r_both    <= w_both_nxt;
      r_drain   <= w_drain_nxt;
      r_mem_err <= w_err_set;
    end
  end

  assign bus.bus_req   = (r_state == REQ);
  assign bus.bus_we    = r_req.we;
  assign bus.bus_addr  = r_req.addr;
  assign bus.bus_wdata = r_req.wdata;

  assign memr_data   = ((r_state == DONE) && r_is_load) ? r_rdata : ERR_DATA;
  assign stall       = w_stall;
  assign mem_err     = r_mem_err;
  assign o_dbg_state = r_state;

endmodule
